// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory controller: access sizes, FSM states
// and the size-to-byte-count helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Reserved size reports zero bytes; it is always flagged as an error.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      SZ_W:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ext.sv
// Load-path byte gather (little-endian, byte 0 lowest) plus sign/zero
// extension of byte, half and word results to XLEN.
module dmem_ext
  import dmem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0][7:0]  bytes_i,
  input  logic [1:0]       size_i,
  input  logic             unsigned_i,
  output logic [XLEN-1:0]  result_o
);

  logic [31:0] gathered;

  always_comb begin
    gathered = bytes_i;
    result_o = '0;
    case (size_i)
      SZ_B: result_o = unsigned_i ? XLEN'(gathered[7:0])
                                  : XLEN'($signed(gathered[7:0]));
      SZ_H: result_o = unsigned_i ? XLEN'(gathered[15:0])
                                  : XLEN'($signed(gathered[15:0]));
      SZ_W: result_o = unsigned_i ? XLEN'(gathered)
                                  : XLEN'($signed(gathered));
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Single-outstanding data-memory controller: IDLE -> WAIT -> RESP with a
// valid/ready request and response. Build option: DMEM_MISALIGN_TRAP_EN.
//
// Handshakes: a transfer happens on a rising edge where valid && ready; the
// sender holds valid and its payload stable until that edge.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 1,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [AW-1:0]   req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output state_e          dbg_state
);

  logic [7:0] mem [DEPTH];

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d, uns_q, uns_d, err_q, err_d;
  logic [1:0]      size_q, size_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;

  logic            accept, enter_resp, req_err;
  logic [AW:0]     req_end;
  logic            op_we, op_uns, op_err;
  logic [1:0]      op_size;
  logic [2:0]      op_nbytes;
  logic [AW-1:0]   op_addr;
  logic [31:0]     op_wdata;
  logic [3:0][7:0] rd_bytes;
  logic [XLEN-1:0] ext_result;

  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;

  always_comb begin
    req_end = {1'b0, req_addr} + (AW+1)'(size_bytes(req_size));
    req_err = (req_size == SZ_RSV) || (req_end > (AW+1)'(DEPTH));
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((req_size == SZ_H && req_addr[0]) ||
        (req_size == SZ_W && req_addr[1:0] != 2'b00)) begin
      req_err = 1'b1;
    end
`endif
  end

  // With no wait cycles the access happens on the accept edge itself, so the
  // operation comes straight from the request port instead of the latches.
  always_comb begin
    op_we     = (state_q == ST_IDLE) ? req_we          : we_q;
    op_uns    = (state_q == ST_IDLE) ? req_unsigned    : uns_q;
    op_err    = (state_q == ST_IDLE) ? req_err         : err_q;
    op_size   = (state_q == ST_IDLE) ? req_size        : size_q;
    op_addr   = (state_q == ST_IDLE) ? req_addr        : addr_q;
    op_wdata  = (state_q == ST_IDLE) ? req_wdata[31:0] : wdata_q;
    op_nbytes = size_bytes(op_size);
    for (int k = 0; k < 4; k++) begin
      rd_bytes[k] = mem[op_addr + AW'(k)];
    end
  end

  dmem_ext #(.XLEN(XLEN)) u_ext (
    .bytes_i    (rd_bytes),
    .size_i     (op_size),
    .unsigned_i (op_uns),
    .result_o   (ext_result)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    uns_d       = uns_q;
    err_d       = err_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    enter_resp  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d    = req_we;
          uns_d   = req_unsigned;
          err_d   = req_err;
          size_d  = req_size;
          addr_d  = req_addr;
          wdata_d = req_wdata[31:0];
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (enter_resp) begin
      rsp_err_d   = op_err;
      rsp_rdata_d = (op_err || op_we) ? '0 : ext_result;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      err_q       <= 1'b0;
      size_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      uns_q       <= uns_d;
      err_q       <= err_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Memory is deliberately outside the reset domain; contents survive rst.
  always_ff @(posedge clk) begin
    if (enter_resp && op_we && !op_err) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < op_nbytes) begin
          mem[op_addr + AW'(k)] <= op_wdata[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl: instance a uses one wait cycle,
// instance b uses three; sel steers the shared request port to one of them.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic        rsp_ready = 1'b1;
  logic [1:0]  req_size = 2'b00;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;

  logic        ready_a, valid_a, err_a, ready_b, valid_b, err_b;
  logic [31:0] rdata_a, rdata_b;
  state_e      state_a, state_b;

  logic        m_ready, m_valid, m_err;
  logic [31:0] m_rdata;
  state_e      m_state;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  dmem_ctrl #(.XLEN(32), .DEPTH(4096), .WAIT_CYCLES(1)) u_dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid && !sel), .req_ready(ready_a),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(valid_a),
    .rsp_ready(rsp_ready), .rsp_rdata(rdata_a), .rsp_err(err_a),
    .dbg_state(state_a)
  );

  dmem_ctrl #(.XLEN(32), .DEPTH(4096), .WAIT_CYCLES(3)) u_dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel), .req_ready(ready_b),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(valid_b),
    .rsp_ready(rsp_ready), .rsp_rdata(rdata_b), .rsp_err(err_b),
    .dbg_state(state_b)
  );

  assign m_ready = sel ? ready_b : ready_a;
  assign m_valid = sel ? valid_b : valid_a;
  assign m_err   = sel ? err_b   : err_a;
  assign m_rdata = sel ? rdata_b : rdata_a;
  assign m_state = sel ? state_b : state_a;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit s, input logic we, input logic [1:0] size,
                       input logic uns, input logic [11:0] addr, input logic [31:0] wdata);
    sel          = s;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
  endtask

  // Latency counts cycles after the accept edge: cycle 1 is the first one.
  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!m_valid && lat < 40);
  endtask

  task automatic txn(input string tag, input bit s, input logic we, input logic [1:0] size,
                     input logic uns, input logic [11:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    int lat;
    exp_q.push_back(exp_rdata);
    @(negedge clk);
    drive(s, we, size, uns, addr, wdata);
    n = 0;
    while (!m_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp(lat);
    check({tag, " latency"}, lat, s ? 4 : 2);
    check({tag, " rdata"}, m_rdata, exp_q.pop_front());
    check({tag, " err"}, m_err, exp_err);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;

    repeat (2) @(negedge clk);
    check("rst req_ready", m_ready, 1'b0);
    check("rst rsp_valid", m_valid, 1'b0);
    check("rst rsp_err", m_err, 1'b0);
    check("rst rsp_rdata", m_rdata, 32'h0);
    check("rst state", m_state, ST_IDLE);
    rst = 1'b0;
    #1 check("post-rst req_ready", m_ready, 1'b1);

    txn("st w 10",   0, 1'b1, SZ_W, 1'b0, 12'h010, 32'hDEADBEEF, 32'h0, 1'b0);
    txn("ld bu 13",  0, 1'b0, SZ_B, 1'b1, 12'h013, 32'h0, 32'h000000DE, 1'b0);
    txn("ld hs 10",  0, 1'b0, SZ_H, 1'b0, 12'h010, 32'h0, 32'hFFFFBEEF, 1'b0);
    txn("ld hu 10",  0, 1'b0, SZ_H, 1'b1, 12'h010, 32'h0, 32'h0000BEEF, 1'b0);
    txn("ld bs 11",  0, 1'b0, SZ_B, 1'b0, 12'h011, 32'h0, 32'hFFFFFFBE, 1'b0);
    txn("st b fff",  0, 1'b1, SZ_B, 1'b0, 12'hFFF, 32'h0000007E, 32'h0, 1'b0);
    txn("st h fff",  0, 1'b1, SZ_H, 1'b0, 12'hFFF, 32'h0000ABCD, 32'h0, 1'b1);
    txn("ld bu fff", 0, 1'b0, SZ_B, 1'b1, 12'hFFF, 32'h0, 32'h0000007E, 1'b0);
    txn("ld rsv",    0, 1'b0, SZ_RSV, 1'b0, 12'h000, 32'h0, 32'h0, 1'b1);
    txn("st w ffc",  0, 1'b1, SZ_W, 1'b0, 12'hFFC, 32'hC0DEF00D, 32'h0, 1'b0);
    txn("ld ws ffc", 0, 1'b0, SZ_W, 1'b0, 12'hFFC, 32'h0, 32'hC0DEF00D, 1'b0);
    txn("st w 20",   0, 1'b1, SZ_W, 1'b0, 12'h020, 32'h11223344, 32'h0, 1'b0);
    txn("st b 24",   0, 1'b1, SZ_B, 1'b0, 12'h024, 32'h00000055, 32'h0, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
    txn("ld w 21",   0, 1'b0, SZ_W, 1'b0, 12'h021, 32'h0, 32'h0, 1'b1);
`else
    txn("ld w 21",   0, 1'b0, SZ_W, 1'b0, 12'h021, 32'h0, 32'h55112233, 1'b0);
`endif

    // Response stall: the held response must not move and the queued
    // request must wait for the handshake.
    @(negedge clk);
    rsp_ready = 1'b0;
    drive(0, 1'b0, SZ_W, 1'b1, 12'h010, 32'h0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp(lat);
    check("hold latency", lat, 2);
    drive(0, 1'b0, SZ_B, 1'b1, 12'h010, 32'h0);
    for (int i = 0; i < 5; i++) begin
      check("hold rsp_valid", m_valid, 1'b1);
      check("hold rsp_rdata", m_rdata, 32'hDEADBEEF);
      check("hold req_ready", m_ready, 1'b0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("after hs req_ready", m_ready, 1'b1);
    check("after hs rsp_valid", m_valid, 1'b0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp(lat);
    check("queued latency", lat, 2);
    check("queued rdata", m_rdata, 32'h000000EF);
    @(posedge clk);
    #1;

    // Reset during WAIT on the three-wait-cycle instance drops the store.
    txn("b st w 20", 1, 1'b1, SZ_W, 1'b0, 12'h020, 32'hA5A5A5A5, 32'h0, 1'b0);
    @(negedge clk);
    drive(1, 1'b1, SZ_W, 1'b0, 12'h020, 32'h11223344);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("b in wait", m_state, ST_WAIT);
    #2 rst = 1'b1;
    #1;
    check("b rst rsp_valid", m_valid, 1'b0);
    check("b rst req_ready", m_ready, 1'b0);
    check("b rst rsp_err", m_err, 1'b0);
    check("b rst rsp_rdata", m_rdata, 32'h0);
    check("b rst state", m_state, ST_IDLE);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check("b post-rst req_ready", m_ready, 1'b1);
    txn("b ld w 20", 1, 1'b0, SZ_W, 1'b1, 12'h020, 32'h0, 32'hA5A5A5A5, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
